// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM state encodings and the
// ALU op codes that the EX stage decodes into start/signed_div.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam logic [5:0] ALU_OP_DIV  = 6'h1A;
    localparam logic [5:0] ALU_OP_DIVU = 6'h1B;

    // Returns {start, signed_div} for an ALU op code.
    function automatic logic [1:0] decode_div_op(input logic [5:0] op);
        case (op)
            ALU_OP_DIV:  return 2'b11;
            ALU_OP_DIVU: return 2'b10;
            default:     return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage (master) and the divider (slave).
interface div_unit_if #(parameter int WIDTH = 32) ();
    logic                 start;
    logic                 signed_div;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 cancel;
    logic                 stall;
    logic                 done;
    logic [2*WIDTH-1:0]   result;

    modport master (output start, signed_div, a, b, cancel,
                    input  stall, done, result);
    modport slave  (input  start, signed_div, a, b, cancel,
                    output stall, done, result);
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift in the next dividend bit and
// trial-subtract the divisor magnitude.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic             dividend_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);
    logic [WIDTH+1:0] shifted_s;
    logic [WIDTH+1:0] trial_s;

    // Trial subtraction; a negative difference restores the shifted remainder.
    always_comb begin
        shifted_s = {rem, dividend_msb};
        trial_s   = shifted_s - {2'b00, divisor};
        if (trial_s[WIDTH+1]) begin
            q_bit    = 1'b0;
            rem_next = shifted_s[WIDTH:0];
        end else begin
            q_bit    = 1'b1;
            rem_next = trial_s[WIDTH:0];
        end
    end
endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: magnitude restoring division with sign fix-up,
// result delivered as {remainder, quotient} in HI/LO layout.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    div_state_e         state_r, state_next_s;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH:0]     rem_r;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   dvs_r;
    logic               sign_q_r, sign_r_r;
    logic [2*WIDTH-1:0] result_r;

    logic               accept_s, last_s, b_zero_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s;
    logic [WIDTH:0]     rem_next_s;
    logic               q_bit_s;
    logic [WIDTH-1:0]   quo_fin_s, q_out_s, r_out_s;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem          (rem_r),
        .dividend_msb (quo_r[WIDTH-1]),
        .divisor      (dvs_r),
        .rem_next     (rem_next_s),
        .q_bit        (q_bit_s)
    );

    // Operand magnitudes, iteration-exit condition and signed fix-up of the final result.
    always_comb begin
        accept_s  = (state_r == DIV_IDLE) && bus.start && !bus.cancel;
        last_s    = (state_r == DIV_BUSY) && (cnt_r == CNT_LAST);
        b_zero_s  = (bus.b == {WIDTH{1'b0}});
        a_mag_s   = (bus.signed_div && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag_s   = (bus.signed_div && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        quo_fin_s = {quo_r[WIDTH-2:0], q_bit_s};
        q_out_s   = sign_q_r ? -quo_fin_s : quo_fin_s;
        r_out_s   = sign_r_r ? -rem_next_s[WIDTH-1:0] : rem_next_s[WIDTH-1:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= DIV_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; cancel aborts anything in flight.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            DIV_IDLE: begin
                if (accept_s) begin
                    state_next_s = b_zero_s ? DIV_DONE : DIV_BUSY;
                end else begin
                    state_next_s = DIV_IDLE;
                end
            end
            DIV_BUSY: begin
                if (bus.cancel) begin
                    state_next_s = DIV_IDLE;
                end else if (last_s) begin
                    state_next_s = DIV_DONE;
                end else begin
                    state_next_s = DIV_BUSY;
                end
            end
            DIV_DONE: state_next_s = DIV_IDLE;
            default:  state_next_s = DIV_IDLE;
        endcase
    end

    // Pipeline-facing outputs; stall drops in DONE so EX captures the result.
    always_comb begin
        bus.stall  = !rst && ((state_r == DIV_BUSY) || accept_s);
        bus.done   = !rst && (state_r == DIV_DONE) && !bus.cancel;
        bus.result = result_r;
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= {CW{1'b0}};
            rem_r    <= {(WIDTH+1){1'b0}};
            quo_r    <= {WIDTH{1'b0}};
            dvs_r    <= {WIDTH{1'b0}};
            sign_q_r <= 1'b0;
            sign_r_r <= 1'b0;
            result_r <= {(2*WIDTH){1'b0}};
        end else if (accept_s) begin
            cnt_r    <= {CW{1'b0}};
            rem_r    <= {(WIDTH+1){1'b0}};
            quo_r    <= a_mag_s;
            dvs_r    <= b_mag_s;
            sign_q_r <= bus.signed_div && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            sign_r_r <= bus.signed_div && bus.a[WIDTH-1];
            // Divide by zero skips iteration: quotient all ones, remainder is the raw dividend.
            if (b_zero_s) begin
                result_r <= {bus.a, {WIDTH{1'b1}}};
            end
        end else if ((state_r == DIV_BUSY) && !bus.cancel) begin
            rem_r <= rem_next_s;
            quo_r <= quo_fin_s;
            if (last_s) begin
                result_r <= {r_out_s, q_out_s};
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed HI/LO cases plus random DIV/DIVU
// checked against a plain-arithmetic reference model.
module tb_div_unit;
    import div_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_unit_if #(.WIDTH(32)) bus ();
    div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [63:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    logic [63:0] last_res;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sbv, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
            q   = sa / sbv;
            r   = sa % sbv;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Monitor: every done pulse must match the oldest expectation, value and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_result"}, bus.result, e.res);
                chk({e.name, "_done_cycle"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp_res, input string name, input bit poke);
        int   n, stalls, lat;
        bit   seen;
        exp_t e;
        lat = (b == 32'd0) ? 1 : 33;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.signed_div = sgn; bus.a = a; bus.b = b;
        n = cyc;
        e.res = exp_res; e.cyc = n + lat; e.name = name;
        sb.push_back(e);
        last_res = exp_res;
        stalls = 0;
        seen   = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (bus.stall === 1'b1) stalls++;
            if (bus.done === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (poke && k == 4) begin
                bus.start = 1'b1; bus.signed_div = ~sgn;
                bus.a = 32'h0000_0063; bus.b = 32'h0000_0005;
            end
        end
        checks++;
        if (!seen) begin
            fails++;
            $display("FAIL %s_timeout: got no done in 60 cycles expected done", name);
        end
        chk({name, "_stall_cycles"}, 64'(stalls), 64'(lat));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1);
    end

    initial begin
        logic [1:0]  dec;
        logic [31:0] ra, rb;
        bit          rs;
        int          sel;

        rst = 1'b1;
        bus.start = 1'b1; bus.signed_div = 1'b0; bus.a = 32'd5; bus.b = 32'd1; bus.cancel = 1'b0;
        @(negedge clk);
        chk("stall_in_reset", 64'(bus.stall), 64'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_result", bus.result, 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_stall", 64'(bus.stall), 64'd0);

        dec = decode_div_op(ALU_OP_DIV);
        chk("decode_div", 64'(dec), 64'd3);

        run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, "divu_100_7", 1'b0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, "div_m7_2", 1'b0);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, "div_7_m2", 1'b0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, "div_ovf", 1'b0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 64'h00000000_FFFFFFFF, "divu_max_1", 1'b0);
        run_div(1'b0, 32'h1234_5678, 32'd0, 64'h12345678_FFFFFFFF, "divu_by0", 1'b0);

        // Cancel at iteration 10: no done, result keeps its previous value.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.signed_div = 1'b0; bus.a = 32'd1000; bus.b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1 bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        @(negedge clk);
        chk("cancel_stall", 64'(bus.stall), 64'd0);
        chk("cancel_done", 64'(bus.done), 64'd0);
        repeat (40) @(negedge clk);
        chk("cancel_result_held", bus.result, last_res);

        // Cancel wins over start in the same IDLE cycle.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.cancel = 1'b1; bus.a = 32'd8; bus.b = 32'd2;
        @(negedge clk);
        chk("cancel_start_stall", 64'(bus.stall), 64'd0);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.cancel = 1'b0;
        @(negedge clk);
        chk("cancel_start_idle", 64'(bus.stall), 64'd0);

        run_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, "divu_9_3", 1'b0);

        // Reset mid-BUSY discards the divide.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.signed_div = 1'b0; bus.a = 32'd77; bus.b = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_busy_stall", 64'(bus.stall), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_stall", 64'(bus.stall), 64'd0);
        chk("post_rst_done", 64'(bus.done), 64'd0);
        chk("post_rst_result", bus.result, 64'd0);
        repeat (40) @(negedge clk);

        // Start while BUSY with other operands is ignored.
        run_div(1'b0, 32'd500, 32'd7, ref_div(1'b0, 32'd500, 32'd7), "start_in_busy", 1'b1);

        for (int i = 0; i < 20; i++) begin
            rs  = 1'($urandom_range(0, 1));
            ra  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0)      rb = 32'd0;
            else if (sel <= 3) rb = 32'($urandom_range(1, 16));
            else if (sel == 4) rb = 32'hFFFF_FFFF;
            else               rb = $urandom;
            if (sel == 5) ra = 32'h8000_0000;
            run_div(rs, ra, rb, ref_div(rs, ra, rb), $sformatf("rand%0d", i), 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
